// File: rtl/vedic_pkg.sv
// Shared constants and helpers for the pipelined Vedic multiplier.
package vedic_pkg;

    // Number of register stages between operand acceptance and product valid.
    localparam int VEDIC_PIPE_LAT = 3;

    // Product width for a w x w multiply.
    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction

    // Legal operand widths: powers of two, at least 2.
    function automatic bit width_ok(input int w);
        return (w >= 2) && ((w & (w - 1)) == 0);
    endfunction

endpackage

// File: rtl/vedic_nxn_comb.sv
// Purely combinational W x W unsigned Urdhva-Tiryakbhyam multiplier.
// Recurses by halving W; bottoms out at a 2x2 AND/half-adder leaf,
// with a 1x1 AND case so the pipelined top also works at WIDTH = 2.
module vedic_nxn_comb
    import vedic_pkg::*;
#(
    parameter int W = 2
)
(
    input  logic [W-1:0]         a,
    input  logic [W-1:0]         b,
    output logic [prod_w(W)-1:0] p
);

    generate
        if (W == 1) begin : g_bit
            assign p = {1'b0, a[0] & b[0]};
        end else if (W == 2) begin : g_leaf
            // Vertical and crosswise terms of the 2x2 leaf.
            logic t_cross_1;
            logic t_cross_2;
            logic t_high;
            logic c_mid;
            assign t_cross_1 = a[1] & b[0];
            assign t_cross_2 = a[0] & b[1];
            assign t_high    = a[1] & b[1];
            assign c_mid     = t_cross_1 & t_cross_2;
            assign p[0]      = a[0] & b[0];
            assign p[1]      = t_cross_1 ^ t_cross_2;
            assign p[2]      = t_high ^ c_mid;
            assign p[3]      = t_high & c_mid;
        end else begin : g_rec
            localparam int H = W / 2;
            logic [W-1:0]   q0;
            logic [W-1:0]   q1;
            logic [W-1:0]   q2;
            logic [W-1:0]   q3;
            logic [W:0]     mid;
            logic [2*W-1:0] e0;
            logic [2*W-1:0] e1;
            logic [2*W-1:0] e3;

            vedic_nxn_comb #(.W(H)) u_q0 (.a(a[H-1:0]), .b(b[H-1:0]), .p(q0));
            vedic_nxn_comb #(.W(H)) u_q1 (.a(a[W-1:H]), .b(b[H-1:0]), .p(q1));
            vedic_nxn_comb #(.W(H)) u_q2 (.a(a[H-1:0]), .b(b[W-1:H]), .p(q2));
            vedic_nxn_comb #(.W(H)) u_q3 (.a(a[W-1:H]), .b(b[W-1:H]), .p(q3));

            // Crosswise sum needs one carry bit beyond W.
            assign mid = {1'b0, q1} + {1'b0, q2};
            assign e0  = {{W{1'b0}}, q0};
            assign e1  = {{(W-1){1'b0}}, mid} << H;
            assign e3  = {q3, {W{1'b0}}};
            assign p   = e0 + e1 + e3;
        end
    endgenerate

endmodule

// File: rtl/vedic_mult_pipe.sv
// Three-stage pipelined WIDTH x WIDTH Vedic multiplier with valid/ready
// handshakes; the whole pipeline freezes while the output is stalled.
// Optional macro VEDIC_SIGNED_EN adds in_signed for two's-complement operands.
module vedic_mult_pipe
    import vedic_pkg::*;
#(
    parameter int WIDTH = 8
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
`ifdef VEDIC_SIGNED_EN
    input  logic                     in_signed,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [prod_w(WIDTH)-1:0] out_product,
    output logic                     busy
);

    localparam int H  = WIDTH / 2;
    localparam int PW = prod_w(WIDTH);

    generate
        if (!width_ok(WIDTH)) begin : g_bad_width
            $error("vedic_mult_pipe: WIDTH must be a power of two >= 2");
        end
    endgenerate

    logic             en;
    logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [WIDTH-1:0] a1_q, a1_d, b1_q, b1_d;
    logic [WIDTH-1:0] q0_q, q0_d, q1_q, q1_d, q2_q, q2_d, q3_q, q3_d;
    logic [WIDTH-1:0] pp0, pp1, pp2, pp3;
    logic [WIDTH:0]   mid;
    logic [PW-1:0]    sum_u;
    logic [PW-1:0]    prod_q, prod_d;
    logic [WIDTH-1:0] a_mag, b_mag;
`ifdef VEDIC_SIGNED_EN
    logic             s1_q, s1_d, s2_q, s2_d, s_in;
`endif

    // Half-width partial products of the S1 operands.
    vedic_nxn_comb #(.W(H)) u_pp0 (.a(a1_q[H-1:0]),     .b(b1_q[H-1:0]),     .p(pp0));
    vedic_nxn_comb #(.W(H)) u_pp1 (.a(a1_q[WIDTH-1:H]), .b(b1_q[H-1:0]),     .p(pp1));
    vedic_nxn_comb #(.W(H)) u_pp2 (.a(a1_q[H-1:0]),     .b(b1_q[WIDTH-1:H]), .p(pp2));
    vedic_nxn_comb #(.W(H)) u_pp3 (.a(a1_q[WIDTH-1:H]), .b(b1_q[WIDTH-1:H]), .p(pp3));

    assign en          = !(v3_q && !out_ready);
    assign in_ready    = en;
    assign out_valid   = v3_q;
    assign out_product = prod_q;
    assign busy        = v1_q | v2_q | v3_q;

    // Operand conditioning: magnitudes in signed mode (most negative maps to itself).
    always_comb begin
`ifdef VEDIC_SIGNED_EN
        s_in  = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
        a_mag = (in_signed && in_a[WIDTH-1]) ? (~in_a + 1'b1) : in_a;
        b_mag = (in_signed && in_b[WIDTH-1]) ? (~in_b + 1'b1) : in_b;
`else
        a_mag = in_a;
        b_mag = in_b;
`endif
    end

    // Next-state for all three stages; everything holds when en is low.
    always_comb begin
        v1_d   = v1_q;
        a1_d   = a1_q;
        b1_d   = b1_q;
        v2_d   = v2_q;
        q0_d   = q0_q;
        q1_d   = q1_q;
        q2_d   = q2_q;
        q3_d   = q3_q;
        v3_d   = v3_q;
        prod_d = prod_q;
        mid    = {1'b0, q1_q} + {1'b0, q2_q};
        sum_u  = {{WIDTH{1'b0}}, q0_q}
               + ({{(WIDTH-1){1'b0}}, mid} << H)
               + {q3_q, {WIDTH{1'b0}}};
`ifdef VEDIC_SIGNED_EN
        s1_d   = s1_q;
        s2_d   = s2_q;
`endif
        if (en) begin
            v1_d = in_valid;
            if (in_valid) begin
                a1_d = a_mag;
                b1_d = b_mag;
`ifdef VEDIC_SIGNED_EN
                s1_d = s_in;
`endif
            end
            v2_d = v1_q;
            if (v1_q) begin
                q0_d = pp0;
                q1_d = pp1;
                q2_d = pp2;
                q3_d = pp3;
`ifdef VEDIC_SIGNED_EN
                s2_d = s1_q;
`endif
            end
            v3_d = v2_q;
            if (v2_q) begin
`ifdef VEDIC_SIGNED_EN
                prod_d = s2_q ? (~sum_u + 1'b1) : sum_u;
`else
                prod_d = sum_u;
`endif
            end
        end
    end

    // Pipeline registers with asynchronous clear; in-flight data is discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            a1_q   <= '0;
            b1_q   <= '0;
            q0_q   <= '0;
            q1_q   <= '0;
            q2_q   <= '0;
            q3_q   <= '0;
            prod_q <= '0;
`ifdef VEDIC_SIGNED_EN
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
`endif
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            v3_q   <= v3_d;
            a1_q   <= a1_d;
            b1_q   <= b1_d;
            q0_q   <= q0_d;
            q1_q   <= q1_d;
            q2_q   <= q2_d;
            q3_q   <= q3_d;
            prod_q <= prod_d;
`ifdef VEDIC_SIGNED_EN
            s1_q   <= s1_d;
            s2_q   <= s2_d;
`endif
        end
    end

endmodule
